// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : legv8_ctrl_pkg
// Description : Shared encodings for the LEGv8 multi-cycle control unit.
//               Opcodes in their 11/10/8/6-bit forms, ALU function-select
//               codes, PC-select codes, branch condition codes, the FSM
//               state enum, the decoded-instruction record and the branch
//               condition evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package legv8_ctrl_pkg;

   // 11-bit opcodes (R-type and D-type)
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11001010000;
   localparam logic [10:0] OP_LSL  = 11'b11010011011;
   localparam logic [10:0] OP_LSR  = 11'b11010011010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_BR   = 11'b11010110000;

   // 10-bit opcodes (I-type)
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [9:0]  OP_ANDI = 10'b1001001000;
   localparam logic [9:0]  OP_ORRI = 10'b1011001000;
   localparam logic [9:0]  OP_EORI = 10'b1101001000;

   // 8-bit opcodes (CB-type)
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;

   // 6-bit opcodes (B-type)
   localparam logic [5:0]  OP_B  = 6'b000101;
   localparam logic [5:0]  OP_BL = 6'b100101;

   // FS = {function[2:0], invert A, invert B + carry-in}
   localparam logic [4:0]  FS_AND = 5'b00000;
   localparam logic [4:0]  FS_ORR = 5'b00100;
   localparam logic [4:0]  FS_ADD = 5'b01000;
   localparam logic [4:0]  FS_SUB = 5'b01001;
   localparam logic [4:0]  FS_EOR = 5'b01100;
   localparam logic [4:0]  FS_LSL = 5'b10000;
   localparam logic [4:0]  FS_LSR = 5'b10100;

   // PC select
   localparam logic [1:0]  PS_HOLD   = 2'b00;
   localparam logic [1:0]  PS_INC    = 2'b01;
   localparam logic [1:0]  PS_BRANCH = 2'b10;
   localparam logic [1:0]  PS_LOAD   = 2'b11;

   // B.cond condition codes
   localparam logic [3:0]  COND_EQ = 4'b0000;
   localparam logic [3:0]  COND_NE = 4'b0001;
   localparam logic [3:0]  COND_HS = 4'b0010;
   localparam logic [3:0]  COND_LO = 4'b0011;
   localparam logic [3:0]  COND_MI = 4'b0100;
   localparam logic [3:0]  COND_PL = 4'b0101;
   localparam logic [3:0]  COND_GE = 4'b1010;
   localparam logic [3:0]  COND_LT = 4'b1011;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_WB    = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   typedef enum logic [3:0] {
      IC_UNKNOWN = 4'd0,
      IC_ALU_R   = 4'd1,
      IC_SHIFT   = 4'd2,
      IC_ALU_I   = 4'd3,
      IC_STUR    = 4'd4,
      IC_LDUR    = 4'd5,
      IC_B       = 4'd6,
      IC_BL      = 4'd7,
      IC_BR      = 4'd8,
      IC_CBZ     = 4'd9,
      IC_CBNZ    = 4'd10,
      IC_BCOND   = 4'd11
   } iclass_e;

   typedef struct packed {
      iclass_e     cls;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [4:0]  rd;        // also Rt
      logic [4:0]  fs;
      logic        set_flags; // ADDS/SUBS
      logic [63:0] imm;
   } decode_t;

   // flags = {V, C, N, Z}; unlisted condition codes are never taken
   function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] flags);
      logic v, c, n, z;
      {v, c, n, z} = flags;
      case (cond)
         COND_EQ: cond_taken = z;
         COND_NE: cond_taken = ~z;
         COND_HS: cond_taken = c;
         COND_LO: cond_taken = ~c;
         COND_MI: cond_taken = n;
         COND_PL: cond_taken = ~n;
         COND_GE: cond_taken = (n == v);
         COND_LT: cond_taken = (n != v);
         default: cond_taken = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_decode.sv
`default_nettype none
// ============================================================================
// Module      : legv8_decode
// Description : Purely combinational instruction decoder. Classifies the IR,
//               extracts register fields, picks the ALU function code and
//               builds the zero/sign-extended constant.
// Ports       : ir_i  [31:0] - latched instruction word
//               dec_o        - decoded record (class, fields, FS, constant)
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [31:0] ir_i,
   output decode_t     dec_o
);

   decode_t w_dec;

   always_comb begin
      w_dec     = '0;
      w_dec.cls = IC_UNKNOWN;
      w_dec.rn  = ir_i[9:5];
      w_dec.rm  = ir_i[20:16];
      w_dec.rd  = ir_i[4:0];

      // Narrowest opcode forms first; the wider forms below override them.
      case (ir_i[31:26])
         OP_B:    w_dec.cls = IC_B;
         OP_BL:   w_dec.cls = IC_BL;
         default: ;
      endcase

      case (ir_i[31:24])
         OP_CBZ:   begin w_dec.cls = IC_CBZ;   w_dec.fs = FS_ADD; end
         OP_CBNZ:  begin w_dec.cls = IC_CBNZ;  w_dec.fs = FS_ADD; end
         OP_BCOND: w_dec.cls = IC_BCOND;
         default:  ;
      endcase

      case (ir_i[31:22])
         OP_ADDI: begin w_dec.cls = IC_ALU_I; w_dec.fs = FS_ADD; end
         OP_SUBI: begin w_dec.cls = IC_ALU_I; w_dec.fs = FS_SUB; end
         OP_ANDI: begin w_dec.cls = IC_ALU_I; w_dec.fs = FS_AND; end
         OP_ORRI: begin w_dec.cls = IC_ALU_I; w_dec.fs = FS_ORR; end
         OP_EORI: begin w_dec.cls = IC_ALU_I; w_dec.fs = FS_EOR; end
         default: ;
      endcase

      case (ir_i[31:21])
         OP_ADD:  begin w_dec.cls = IC_ALU_R; w_dec.fs = FS_ADD; end
         OP_SUB:  begin w_dec.cls = IC_ALU_R; w_dec.fs = FS_SUB; end
         OP_AND:  begin w_dec.cls = IC_ALU_R; w_dec.fs = FS_AND; end
         OP_ORR:  begin w_dec.cls = IC_ALU_R; w_dec.fs = FS_ORR; end
         OP_EOR:  begin w_dec.cls = IC_ALU_R; w_dec.fs = FS_EOR; end
         OP_ADDS: begin w_dec.cls = IC_ALU_R; w_dec.fs = FS_ADD; w_dec.set_flags = 1'b1; end
         OP_SUBS: begin w_dec.cls = IC_ALU_R; w_dec.fs = FS_SUB; w_dec.set_flags = 1'b1; end
         OP_LSL:  begin w_dec.cls = IC_SHIFT; w_dec.fs = FS_LSL; end
         OP_LSR:  begin w_dec.cls = IC_SHIFT; w_dec.fs = FS_LSR; end
         OP_STUR: begin w_dec.cls = IC_STUR;  w_dec.fs = FS_ADD; end
         OP_LDUR: begin w_dec.cls = IC_LDUR;  w_dec.fs = FS_ADD; end
         OP_BR:   begin w_dec.cls = IC_BR;    w_dec.fs = FS_ADD; end
         default: ;
      endcase

      case (w_dec.cls)
         IC_SHIFT:                   w_dec.imm = {58'd0, ir_i[15:10]};
         IC_ALU_I:                   w_dec.imm = {52'd0, ir_i[21:10]};
         IC_STUR, IC_LDUR:           w_dec.imm = {{55{ir_i[20]}}, ir_i[20:12]};
         IC_B, IC_BL:                w_dec.imm = {{38{ir_i[25]}}, ir_i[25:0]};
         IC_CBZ, IC_CBNZ, IC_BCOND:  w_dec.imm = {{45{ir_i[23]}}, ir_i[23:5]};
         default:                    w_dec.imm = '0;
      endcase
   end

   assign dec_o = w_dec;

endmodule
`default_nettype wire

// File: rtl/legv8_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : legv8_control_fsm
// Description : Multi-cycle LEGv8 control unit. Latches the instruction in
//               FETCH, drives the datapath control word in EXEC (and WB for
//               LDUR), and parks in HALT on an unrecognised opcode.
// Ports       : clock        - rising-edge clock
//               reset        - synchronous active-high reset
//               instruction  - ROM word at current PC
//               status       - {V,C,N,Z} in [4:1], live ALU zero in [0]
//               ControlWord  - {SA,SB,DA,RegWrite,MemWrite,FS,Bsel,EN_Mem,EN_ALU}
//               constant     - immediate / branch word offset
//               PS           - PC select
//               EN_PC        - drive PC+4 onto data bus
//               SL           - load status register
//               halted       - high in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_control_fsm
   import legv8_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [4:0]  status,
   output logic [24:0] ControlWord,
   output logic [63:0] constant,
   output logic [1:0]  PS,
   output logic        EN_PC,
   output logic        SL,
   output logic        halted
);

   state_e      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   decode_t     w_dec;

   logic [4:0]  w_sa, w_sb, w_da, w_fs;
   logic        w_rw, w_mw, w_bsel, w_en_mem, w_en_alu;
   logic [63:0] w_k;
   logic [1:0]  w_ps;
   logic        w_en_pc, w_sl, w_halted;

   legv8_decode u_decode (
      .ir_i  (ir_q),
      .dec_o (w_dec)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      w_sa     = '0;
      w_sb     = '0;
      w_da     = '0;
      w_fs     = '0;
      w_rw     = 1'b0;
      w_mw     = 1'b0;
      w_bsel   = 1'b0;
      w_en_mem = 1'b0;
      w_en_alu = 1'b0;
      w_k      = '0;
      w_ps     = PS_HOLD;
      w_en_pc  = 1'b0;
      w_sl     = 1'b0;
      w_halted = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_d    = instruction;
            state_d = S_EXEC;
         end

         S_EXEC: begin
            state_d = S_FETCH;
            case (w_dec.cls)
               IC_ALU_R, IC_SHIFT: begin
                  w_sa = w_dec.rn; w_sb = w_dec.rm; w_da = w_dec.rd;
                  w_fs = w_dec.fs; w_rw = 1'b1; w_en_alu = 1'b1; w_ps = PS_INC;
                  // Shifts take the shamt through the constant port
                  w_bsel = (w_dec.cls == IC_SHIFT);
                  w_k    = w_dec.imm;
                  w_sl   = w_dec.set_flags;
               end
               IC_ALU_I: begin
                  w_sa = w_dec.rn; w_da = w_dec.rd; w_fs = w_dec.fs; w_bsel = 1'b1;
                  w_k  = w_dec.imm; w_rw = 1'b1; w_en_alu = 1'b1; w_ps = PS_INC;
               end
               IC_STUR, IC_LDUR: begin
                  w_sa = w_dec.rn; w_sb = w_dec.rd; w_fs = w_dec.fs; w_bsel = 1'b1;
                  w_k  = w_dec.imm;
                  if (w_dec.cls == IC_STUR) begin
                     w_mw = 1'b1;
                     w_ps = PS_INC;
                  end else begin
                     // Address goes out now; register write happens in WB
                     state_d = S_WB;
                  end
               end
               IC_B, IC_BL: begin
                  w_ps = PS_BRANCH;
                  w_k  = w_dec.imm;
                  if (w_dec.cls == IC_BL) begin
                     w_da = 5'd30; w_rw = 1'b1; w_en_pc = 1'b1;
                  end
               end
               IC_BR: begin
                  // XZR on B makes the ALU pass Rn through to the PC
                  w_sa = w_dec.rn; w_sb = 5'd31; w_fs = w_dec.fs;
                  w_en_alu = 1'b1; w_ps = PS_LOAD;
               end
               IC_CBZ, IC_CBNZ: begin
                  // 0 + Rt on the ALU; status[0] reports whether Rt is zero
                  w_sa = 5'd31; w_sb = w_dec.rd; w_fs = w_dec.fs; w_k = w_dec.imm;
                  w_ps = ((w_dec.cls == IC_CBZ) == status[0]) ? PS_BRANCH : PS_INC;
               end
               IC_BCOND: begin
                  w_k  = w_dec.imm;
                  w_ps = cond_taken(ir_q[3:0], status[4:1]) ? PS_BRANCH : PS_INC;
               end
               default: state_d = S_HALT;
            endcase
         end

         S_WB: begin
            w_sa = w_dec.rn; w_fs = w_dec.fs; w_bsel = 1'b1; w_k = w_dec.imm;
            w_da = w_dec.rd; w_rw = 1'b1; w_en_mem = 1'b1; w_ps = PS_INC;
            state_d = S_FETCH;
         end

         S_HALT: begin
            w_halted = 1'b1;
         end

         default: state_d = S_FETCH;
      endcase

      // Reset masks every output so an aborted instruction commits nothing
      if (reset) begin
         w_sa = '0; w_sb = '0; w_da = '0; w_fs = '0;
         w_rw = 1'b0; w_mw = 1'b0; w_bsel = 1'b0; w_en_mem = 1'b0; w_en_alu = 1'b0;
         w_k  = '0; w_ps = PS_HOLD; w_en_pc = 1'b0; w_sl = 1'b0; w_halted = 1'b0;
      end
   end

   assign ControlWord = {w_sa, w_sb, w_da, w_rw, w_mw, w_fs, w_bsel, w_en_mem, w_en_alu};
   assign constant    = w_k;
   assign PS          = w_ps;
   assign EN_PC       = w_en_pc;
   assign SL          = w_sl;
   assign halted      = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_legv8_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_legv8_control_fsm
// Description : Scoreboard bench for legv8_control_fsm. The stimulus process
//               acts as the instruction ROM, predicts every cycle's outputs
//               from an instruction-level model and queues them; a monitor
//               on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_legv8_control_fsm;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction = '0;
   logic [4:0]  status = '0;
   logic [24:0] cw;
   logic [63:0] k;
   logic [1:0]  ps;
   logic        en_pc, sl, halted;

   legv8_control_fsm dut (
      .clock       (clock),
      .reset       (reset),
      .instruction (instruction),
      .status      (status),
      .ControlWord (cw),
      .constant    (k),
      .PS          (ps),
      .EN_PC       (en_pc),
      .SL          (sl),
      .halted      (halted)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [24:0] cw;
      logic [63:0] k;
      logic [1:0]  ps;
      logic        en_pc;
      logic        sl;
      logic        halted;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   // Bench-side view of where the current instruction is:
   // 0 = about to fetch, 1 = executing, 2 = LDUR writeback, 3 = halted
   int          phase = 0;
   logic [31:0] m_ir  = '0;

   // Opcode table for random generation: value and width (index 21 = unknown)
   logic [31:0] opv [21] = '{32'h458, 32'h558, 32'h658, 32'h758, 32'h450, 32'h550,
                             32'h650, 32'h69B, 32'h69A, 32'h7C0, 32'h7C2, 32'h6B0,
                             32'h244, 32'h344, 32'h248, 32'h2C8, 32'h348,
                             32'hB4, 32'hB5, 32'h54, 32'h05};
   int          opw [21] = '{11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11,
                             10, 10, 10, 10, 10, 8, 8, 8, 6};

   function automatic string mnem(input logic [31:0] ir);
      int unsigned o11, o10, o8, o6;
      o11 = ir >> 21; o10 = ir >> 22; o8 = ir >> 24; o6 = ir >> 26;
      if (o11 == 'h458) return "ADD";
      if (o11 == 'h558) return "ADDS";
      if (o11 == 'h658) return "SUB";
      if (o11 == 'h758) return "SUBS";
      if (o11 == 'h450) return "AND";
      if (o11 == 'h550) return "ORR";
      if (o11 == 'h650) return "EOR";
      if (o11 == 'h69B) return "LSL";
      if (o11 == 'h69A) return "LSR";
      if (o11 == 'h7C0) return "STUR";
      if (o11 == 'h7C2) return "LDUR";
      if (o11 == 'h6B0) return "BR";
      if (o10 == 'h244) return "ADDI";
      if (o10 == 'h344) return "SUBI";
      if (o10 == 'h248) return "ANDI";
      if (o10 == 'h2C8) return "ORRI";
      if (o10 == 'h348) return "EORI";
      if (o8  == 'hB4)  return "CBZ";
      if (o8  == 'hB5)  return "CBNZ";
      if (o8  == 'h54)  return "BCOND";
      if (o6  == 'h05)  return "B";
      if (o6  == 'h25)  return "BL";
      return "UNK";
   endfunction

   function automatic logic [4:0] fs_of(input string m);
      if (m == "SUB" || m == "SUBS" || m == "SUBI") return 5'b01001;
      if (m == "AND" || m == "ANDI")                return 5'b00000;
      if (m == "ORR" || m == "ORRI")                return 5'b00100;
      if (m == "EOR" || m == "EORI")                return 5'b01100;
      if (m == "LSL")                               return 5'b10000;
      if (m == "LSR")                               return 5'b10100;
      return 5'b01000;
   endfunction

   // Expected outputs of the EXEC (wb=0) or WB (wb=1) cycle for word ir
   function automatic exp_t model(input logic [31:0] ir, input logic [4:0] st, input bit wb);
      exp_t   e;
      string  m;
      int     rd, rn, rm, sa, sb, da;
      bit     rw, mw, bs, em, ea, taken, v, c, n, z;
      longint s9, s19, s26;
      logic [4:0] fs;
      e  = '0;
      m  = mnem(ir);
      rd = int'(ir[4:0]); rn = int'(ir[9:5]); rm = int'(ir[20:16]);
      s9  = longint'(ir[20:12]); if (s9  >= 256)      s9  -= 512;
      s19 = longint'(ir[23:5]);  if (s19 >= (1 << 18)) s19 -= (1 << 19);
      s26 = longint'(ir[25:0]);  if (s26 >= (1 << 25)) s26 -= (1 << 26);
      {v, c, n, z} = st[4:1];
      sa = 0; sb = 0; da = 0; rw = 0; mw = 0; bs = 0; em = 0; ea = 0; fs = 5'b0;
      if (wb) begin
         sa = rn; da = rd; bs = 1; fs = 5'b01000; rw = 1; em = 1;
         e.k = s9; e.ps = 2'b01;
      end else if (m == "ADD" || m == "SUB" || m == "AND" || m == "ORR" ||
                   m == "EOR" || m == "ADDS" || m == "SUBS") begin
         sa = rn; sb = rm; da = rd; rw = 1; ea = 1; fs = fs_of(m); e.ps = 2'b01;
         e.sl = (m == "ADDS" || m == "SUBS");
      end else if (m == "LSL" || m == "LSR") begin
         sa = rn; sb = rm; da = rd; rw = 1; ea = 1; bs = 1; fs = fs_of(m);
         e.k = longint'(ir[15:10]); e.ps = 2'b01;
      end else if (m == "ADDI" || m == "SUBI" || m == "ANDI" || m == "ORRI" || m == "EORI") begin
         sa = rn; da = rd; rw = 1; ea = 1; bs = 1; fs = fs_of(m);
         e.k = longint'(ir[21:10]); e.ps = 2'b01;
      end else if (m == "STUR" || m == "LDUR") begin
         sa = rn; sb = rd; bs = 1; fs = 5'b01000; e.k = s9;
         mw = (m == "STUR"); e.ps = (m == "STUR") ? 2'b01 : 2'b00;
      end else if (m == "B" || m == "BL") begin
         e.ps = 2'b10; e.k = s26;
         if (m == "BL") begin da = 30; rw = 1; e.en_pc = 1; end
      end else if (m == "BR") begin
         sa = rn; sb = 31; fs = 5'b01000; ea = 1; e.ps = 2'b11;
      end else if (m == "CBZ" || m == "CBNZ") begin
         sa = 31; sb = rd; fs = 5'b01000; e.k = s19;
         taken = (m == "CBZ") ? st[0] : !st[0];
         e.ps = taken ? 2'b10 : 2'b01;
      end else if (m == "BCOND") begin
         e.k = s19;
         case (int'(ir[3:0]))
            0: taken = z;          1: taken = !z;
            2: taken = c;          3: taken = !c;
            4: taken = n;          5: taken = !n;
            10: taken = (n == v);  11: taken = (n != v);
            default: taken = 0;
         endcase
         e.ps = taken ? 2'b10 : 2'b01;
      end
      e.cw = {5'(sa), 5'(sb), 5'(da), rw, mw, fs, bs, em, ea};
      return e;
   endfunction

   // One clock of stimulus; fw is presented only when a fetch is due
   task automatic step(input logic [31:0] fw, input logic [4:0] st, input bit rst, input string tag);
      exp_t e;
      @(posedge clock); #1;
      instruction = (phase == 0) ? fw : $urandom;
      status      = st;
      reset       = rst;
      e           = '0;
      if (rst) begin
         phase = 0;
      end else begin
         case (phase)
            0: begin m_ir = fw; phase = 1; end
            1: begin
               e = model(m_ir, st, 1'b0);
               if (mnem(m_ir) == "LDUR")     phase = 2;
               else if (mnem(m_ir) == "UNK") phase = 3;
               else                          phase = 0;
            end
            2: begin e = model(m_ir, st, 1'b1); phase = 0; end
            default: e.halted = 1'b1;
         endcase
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Runs one instruction to completion; reset is asserted at cycle abort_at
   task automatic run_instr(input logic [31:0] w, input logic [4:0] st, input int abort_at, input string tag);
      int n;
      n = 0;
      do begin
         step(w, st, (n == abort_at), tag);
         n++;
      end while (phase != 0 && phase != 3 && n < 5);
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (cw !== e.cw || k !== e.k || ps !== e.ps || en_pc !== e.en_pc ||
             sl !== e.sl || halted !== e.halted) begin
            errors++;
            $display("FAIL %s @%0t: got cw=%h k=%h ps=%b pc=%b sl=%b h=%b, want cw=%h k=%h ps=%b pc=%b sl=%b h=%b",
                     t, $time, cw, k, ps, en_pc, sl, halted,
                     e.cw, e.k, e.ps, e.en_pc, e.sl, e.halted);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          idx, ab;
      logic [31:0] w;

      // Reset for two cycles
      step(32'h0, 5'h0, 1'b1, "reset");
      step(32'h0, 5'h0, 1'b1, "reset");

      run_instr(32'h8B020023, 5'h1F, -1, "ADD");
      run_instr(32'hF85F8025, 5'h00, -1, "LDUR");
      run_instr(32'hF85F8025, 5'h00,  2, "LDUR_abort_wb");
      run_instr(32'hB4000064, 5'h01, -1, "CBZ_taken");
      run_instr(32'hB4000064, 5'h00, -1, "CBZ_not_taken");
      run_instr(32'h54000060, 5'h00, -1, "BEQ_not_taken");
      run_instr(32'h54000060, 5'h02, -1, "BEQ_taken");
      run_instr(32'h97FFFFFE, 5'h00, -1, "BL");
      run_instr(32'hAB020023, 5'h00, -1, "ADDS");
      run_instr(32'h00000000, 5'h00, -1, "HALT_entry");
      repeat (10) step(32'h8B020023, 5'h1F, 1'b0, "HALT_hold");
      step(32'h0, 5'h0, 1'b1, "HALT_reset");
      run_instr(32'h8B020023, 5'h00, -1, "ADD_after_halt");

      // Randomized instruction stream
      for (int i = 0; i < 400; i++) begin
         idx = $urandom_range(0, 21);
         w   = $urandom;
         if (idx == 21) begin
            w = w & 32'h03FFFFFF;
         end else begin
            w = (w & ((32'h1 << (32 - opw[idx])) - 32'h1)) | (opv[idx] << (32 - opw[idx]));
            if (idx == 20 && $urandom_range(0, 1) == 1) w[31] = 1'b1;  // BL
         end
         ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 2) : -1;
         run_instr(w, 5'($urandom), ab, "random");
         if (phase == 3) begin
            repeat (3) step($urandom, 5'($urandom), 1'b0, "random_halt");
            step(32'h0, 5'($urandom), 1'b1, "random_reset");
         end
      end

      @(posedge clock);
      @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/legv8_control_fsm.md
# legv8_control_fsm

Multi-cycle control unit for the LEGv8 datapath. It latches each instruction word from the instruction ROM and decodes it. It then sequences FETCH/EXEC/WB cycles that drive the datapath's 25-bit control word, the constant bus, the program-counter select, and the status-load strobe. It is the producer of every control signal the datapath consumes, and it reads back only the datapath's 5-bit status.

## Interface
Parameters: none; all encodings live in the shared package.

Ports:
- `clock` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `instruction` in 32: ROM output at the current PC, valid combinationally.
- `status` in 5: {V,C,N,Z} latched in [4:1]; live ALU zero in [0].
- `ControlWord` out 25: {SA[4:0], SB[4:0], DA[4:0], RegWrite, MemWrite, FS[4:0], Bsel, EN_Mem, EN_ALU}.
- `constant` out 64: immediate or branch word offset.
- `PS` out 2: PC select. 00 = hold, 01 = PC+4, 10 = PC + (constant<<2), 11 = load from data bus.
- `EN_PC` out 1: drives PC+4 onto the data bus.
- `SL` out 1: load status register.
- `halted` out 1: set in the HALT state.

## Operation
States: FETCH, EXEC, WB, HALT.

FETCH:
- Latches `instruction` into the internal IR.
- All outputs are 0; PS=00.
- Next state: EXEC.

EXEC decodes the IR. Field positions: Rd=[4:0], Rn=[9:5], Rm=[20:16], Rt=[4:0].
- R-type ADD/SUB/AND/ORR/EOR/ADDS/SUBS:
  - SA=Rn, SB=Rm, DA=Rd, Bsel=0, RegWrite=1, EN_ALU=1, PS=01.
  - SL=1 only for ADDS/SUBS.
- LSL/LSR:
  - SA=Rn, Bsel=1, constant = zero-extended shamt [15:10].
- I-type ADDI/SUBI/ANDI/ORRI/EORI:
  - SA=Rn, DA=Rd, Bsel=1, constant = zero-extended [21:10], RegWrite=1, EN_ALU=1, PS=01.
- STUR:
  - SA=Rn, SB=Rt, Bsel=1, constant = sign-extended [20:12], FS=ADD, MemWrite=1, PS=01.
- LDUR, EXEC cycle:
  - Same address setup as STUR; RegWrite=0, PS=00.
  - Next state: WB.
- LDUR, WB cycle:
  - Identical SA/FS/Bsel/constant.
  - DA=Rt, RegWrite=1, EN_Mem=1, PS=01.
- B: PS=10, constant = sign-extended [25:0].
- BL: as B, plus DA=30, RegWrite=1, EN_PC=1.
- BR: SA=Rn, SB=31, FS=ADD, Bsel=0, EN_ALU=1, PS=11.
- CBZ/CBNZ:
  - SA=31, SB=Rt, Bsel=0, FS=ADD, no bus enable.
  - constant = sign-extended [23:5].
  - PS=10 if the taken condition on `status[0]` holds, else 01.
- B.cond:
  - cond = [3:0].
  - EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N; GE 1010 N==V; LT 1011 N!=V.
  - Taken: PS=10. Not taken: PS=01. Any other cond is not taken.
  - constant = sign-extended [23:5].
- Any other opcode, including all-zero: next state HALT; all outputs 0 for that cycle.

Next state after EXEC: FETCH, except LDUR (WB) and unknown opcode (HALT).

FS codes:
- FS[4:2] selects the function: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR.
- FS[1] inverts A; FS[0] inverts B and sets carry-in.
- Resulting codes: ADD 01000, SUB 01001, AND 00000, ORR 00100, EOR 01100, LSL 10000, LSR 10100.

HALT:
- All outputs 0, `halted`=1.
- Leaves only on reset.

## Timing
- Outputs are combinational from state and IR, plus `status` for CBZ/CBNZ/B.cond. There is no output register.
- Latency per instruction:
  - 2 cycles: FETCH + EXEC.
  - 3 cycles for LDUR: FETCH + EXEC + WB.
- The PC changes only at the end of EXEC/WB; it is constant through FETCH.
- Branch offsets are relative to the PC of the branch instruction.
- Reset:
  - While `reset`=1, all outputs are forced to 0 and `halted`=0.
  - At the edge, state becomes FETCH and IR becomes 0.
  - Reset in EXEC or WB aborts the instruction: no RegWrite, MemWrite, or PC update is seen at that edge.
- An unknown opcode never asserts RegWrite, MemWrite, or SL.

## Structure
- Package `legv8_ctrl_pkg` holds:
  - opcode constants (11-, 10-, 8- and 6-bit forms);
  - FS codes;
  - PS codes;
  - cond codes;
  - the state enum.
- Sub-module `legv8_decode`: purely combinational. Maps IR to an instruction class, register fields, and the extended constant. The FSM handles sequencing and the branch decision.

## Test plan
- Reset for 2 cycles, then release:
  - All outputs are 0 throughout reset.
  - The first cycle after release is FETCH with PS=00.
- ADD X3,X1,X2 (0x8B020023), in EXEC:
  - SA=1, SB=2, DA=3, FS=01000, Bsel=0, RegWrite=1, EN_ALU=1, SL=0, PS=01.
  - The next cycle is FETCH.
- LDUR X5,[X1,#-8] (0xF85F8025):
  - EXEC: constant=0xFFFFFFFFFFFFFFF8, Bsel=1, FS=01000, RegWrite=0, PS=00.
  - WB: DA=5, RegWrite=1, EN_Mem=1, PS=01.
  - Repeat with reset asserted in WB: no RegWrite.
- CBZ X4,#3 (0xB4000064):
  - With status[0]=1: PS=10, constant=3.
  - With status[0]=0: PS=01.
  - B.EQ (0x54000060) with status[1]=0: PS=01.
- BL #-2 (0x97FFFFFE), in EXEC:
  - DA=30, RegWrite=1, EN_PC=1, PS=10, constant=0xFFFFFFFFFFFFFFFE.
- Instruction 0x00000000:
  - Enters HALT; halted=1 and all outputs 0 for 10 cycles.
  - Reset returns the block to FETCH with halted=0.
